// File: rtl/scrambler_ctrl_tx.sv
// Tx scrambler control for one PCIe lane: per-byte scramble-enable, LFSR advance and
// LFSR reseed flags for 8b/10b and 128b/130b, registered alongside the data.
module scrambler_ctrl_tx #(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] SKP_G12    = 8'h1C,
    parameter logic [7:0] COM_G12    = 8'hBC
) (
    input  logic                    pclk,
    input  logic                    reset_n,
    input  logic [2:0]              gen,
    input  logic                    scr_disable,
    input  logic                    in_valid,
    input  logic [8*DATA_BYTES-1:0] data_in,
    input  logic [DATA_BYTES-1:0]   datak_in,
    input  logic                    block_start,
    input  logic [1:0]              sync_header,
    output logic                    out_valid,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic [DATA_BYTES-1:0]   datak_out,
    output logic [DATA_BYTES-1:0]   scr_en,
    output logic [DATA_BYTES-1:0]   advance,
    output logic [DATA_BYTES-1:0]   pattern_reset,
    output logic                    block_err
);

    typedef enum logic [2:0] {
        BT_OTHER,
        BT_DATA,
        BT_TS1,
        BT_TS2,
        BT_SKP,
        BT_EIEOS
    } blk_type_t;

    localparam logic [4:0] STEP = 5'(DATA_BYTES);

    logic [3:0]  sym_cnt;
    logic        in_block;
    blk_type_t   blk_type;
    logic [2:0]  prev_gen;

    logic                  gen_chg;
    logic [3:0]            cur_cnt;
    logic                  cur_in_block;
    blk_type_t             hdr_type;
    logic                  hdr_bad;
    blk_type_t             eff_type;
    blk_type_t             n_blk_type;
    logic [3:0]            base;
    logic [3:0]            sym;
    logic [4:0]            step_sum;
    logic [3:0]            n_sym;
    logic                  n_in_block;
    logic                  n_err;
    logic [DATA_BYTES-1:0] n_scr;
    logic [DATA_BYTES-1:0] n_adv;
    logic [DATA_BYTES-1:0] n_prst;

    always_comb begin
        // A generation change abandons any block in progress.
        gen_chg      = (gen != prev_gen);
        cur_cnt      = gen_chg ? 4'd0 : sym_cnt;
        cur_in_block = gen_chg ? 1'b0 : in_block;

        hdr_bad  = 1'b0;
        hdr_type = BT_OTHER;
        case (sync_header)
            2'b01: hdr_type = BT_DATA;
            2'b10: begin
                case (data_in[7:0])
                    8'h1E:   hdr_type = BT_TS1;
                    8'h2D:   hdr_type = BT_TS2;
                    8'hAA:   hdr_type = BT_SKP;
                    8'h00:   hdr_type = BT_EIEOS;
                    default: hdr_type = BT_OTHER;
                endcase
            end
            default: hdr_bad = 1'b1;
        endcase

        n_sym      = cur_cnt;
        n_in_block = cur_in_block;
        n_blk_type = blk_type;
        eff_type   = BT_OTHER;
        base       = cur_cnt;
        step_sum   = 5'd0;
        sym        = 4'd0;
        n_err      = 1'b0;
        n_scr      = '0;
        n_adv      = '0;
        n_prst     = '0;

        if (gen >= 3'd3) begin
            if (block_start) begin
                n_err      = hdr_bad || (cur_in_block && cur_cnt != 4'd0);
                eff_type   = hdr_type;
                n_blk_type = hdr_type;
                base       = 4'd0;
            end else if (cur_in_block) begin
                eff_type = blk_type;
            end else begin
                n_err = 1'b1;
            end
            // Orphan words outside a block do not move the symbol counter.
            if (block_start || cur_in_block) begin
                step_sum   = {1'b0, base} + STEP;
                n_sym      = step_sum[3:0];
                n_in_block = (step_sum[3:0] != 4'd0);
            end
            for (int k = 0; k < DATA_BYTES; k++) begin
                sym = base + 4'(k);
                case (eff_type)
                    BT_DATA: begin
                        n_scr[k] = 1'b1;
                        n_adv[k] = 1'b1;
                    end
                    BT_TS1, BT_TS2: begin
                        n_scr[k] = (sym != 4'd0);
                        n_adv[k] = 1'b1;
                    end
                    BT_SKP: begin
                        n_adv[k] = 1'b0;
                    end
                    BT_EIEOS: begin
                        n_adv[k]  = 1'b1;
                        n_prst[k] = (sym == 4'd15);
                    end
                    default: n_adv[k] = 1'b1;
                endcase
            end
            if (scr_disable) n_scr = '0;
        end else begin
            for (int k = 0; k < DATA_BYTES; k++) begin
                if (datak_in[k] && data_in[8*k +: 8] == COM_G12) begin
                    n_adv[k]  = 1'b1;
                    n_prst[k] = 1'b1;
                end else if (data_in[8*k +: 8] == SKP_G12) begin
                    n_adv[k] = 1'b0;
                end else if (datak_in[k]) begin
                    n_adv[k] = 1'b1;
                end else begin
                    n_adv[k] = 1'b1;
                    n_scr[k] = ~scr_disable;
                end
            end
            if (scr_disable) n_prst = '1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            data_out      <= '0;
            datak_out     <= '0;
            scr_en        <= '0;
            advance       <= '0;
            pattern_reset <= '0;
            block_err     <= 1'b0;
            sym_cnt       <= 4'd0;
            in_block      <= 1'b0;
            blk_type      <= BT_OTHER;
            prev_gen      <= 3'd0;
        end else begin
            out_valid <= in_valid;
            block_err <= in_valid && n_err;
            if (in_valid) begin
                data_out      <= data_in;
                datak_out     <= datak_in;
                scr_en        <= n_scr;
                advance       <= n_adv;
                pattern_reset <= n_prst;
                sym_cnt       <= n_sym;
                in_block      <= n_in_block;
                blk_type      <= n_blk_type;
                prev_gen      <= gen;
            end else begin
                scr_en        <= '0;
                advance       <= '0;
                pattern_reset <= '0;
            end
        end
    end

endmodule

// File: tb/tb_scrambler_ctrl_tx.sv
// Bench for scrambler_ctrl_tx (4 bytes/cycle): directed plan steps plus randomized
// traffic, compared against a symbol-position reference model.
module tb_scrambler_ctrl_tx;

    logic        pclk;
    logic        reset_n;
    logic [2:0]  gen;
    logic        scr_disable;
    logic        in_valid;
    logic [31:0] data_in;
    logic [3:0]  datak_in;
    logic        block_start;
    logic [1:0]  sync_header;
    logic        out_valid;
    logic [31:0] data_out;
    logic [3:0]  datak_out;
    logic [3:0]  scr_en;
    logic [3:0]  advance;
    logic [3:0]  pattern_reset;
    logic        block_err;

    scrambler_ctrl_tx #(.DATA_BYTES(4)) dut (
        .pclk(pclk), .reset_n(reset_n), .gen(gen), .scr_disable(scr_disable),
        .in_valid(in_valid), .data_in(data_in), .datak_in(datak_in),
        .block_start(block_start), .sync_header(sync_header),
        .out_valid(out_valid), .data_out(data_out), .datak_out(datak_out),
        .scr_en(scr_en), .advance(advance), .pattern_reset(pattern_reset),
        .block_err(block_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Block kinds used by the reference model
    localparam int K_OTHER = 0, K_DATA = 1, K_TS1 = 2, K_TS2 = 3, K_SKP = 4, K_EIE = 5;

    int m_gen, m_pos, m_kind;
    bit m_live;
    logic        e_valid, e_err;
    logic [31:0] e_data;
    logic [3:0]  e_datak, e_scr, e_adv, e_prst;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int classify(logic [1:0] sh, logic [7:0] b0, output bit bad);
        bad = 1'b0;
        if (sh == 2'b01) return K_DATA;
        if (sh != 2'b10) begin
            bad = 1'b1;
            return K_OTHER;
        end
        case (b0)
            8'h1E:   return K_TS1;
            8'h2D:   return K_TS2;
            8'hAA:   return K_SKP;
            8'h00:   return K_EIE;
            default: return K_OTHER;
        endcase
    endfunction

    task automatic model_reset();
        m_gen = 0; m_pos = 0; m_live = 0; m_kind = K_OTHER;
        e_valid = 0; e_err = 0; e_data = '0; e_datak = '0;
        e_scr = '0; e_adv = '0; e_prst = '0;
    endtask

    task automatic model_step(bit v, bit [2:0] g, bit dis, logic [31:0] d, logic [3:0] k,
                              bit bs, logic [1:0] sh);
        int kind, first, s;
        bit bad, counts;
        logic [7:0] b;
        e_valid = v; e_err = 0; e_scr = '0; e_adv = '0; e_prst = '0;
        if (!v) return;
        e_data = d; e_datak = k;
        if (int'(g) != m_gen) begin
            m_gen = int'(g); m_pos = 0; m_live = 0;
        end
        if (g < 3) begin
            for (int i = 0; i < 4; i++) begin
                b = d[8*i +: 8];
                if (k[i] && b == 8'hBC) begin
                    e_adv[i] = 1; e_prst[i] = 1;
                end else if (b == 8'h1C) begin
                    e_adv[i] = 0;
                end else if (k[i]) begin
                    e_adv[i] = 1;
                end else begin
                    e_adv[i] = 1; e_scr[i] = !dis;
                end
            end
            if (dis) e_prst = 4'hF;
        end else begin
            if (bs) begin
                kind = classify(sh, d[7:0], bad);
                if (bad || (m_live && m_pos != 0)) e_err = 1;
                m_kind = kind; first = 0; counts = 1;
            end else if (m_live) begin
                kind = m_kind; first = m_pos; counts = 1;
            end else begin
                e_err = 1; kind = K_OTHER; first = m_pos; counts = 0;
            end
            for (int i = 0; i < 4; i++) begin
                s = (first + i) % 16;
                case (kind)
                    K_DATA:       begin e_scr[i] = 1; e_adv[i] = 1; end
                    K_TS1, K_TS2: begin e_scr[i] = (s >= 1); e_adv[i] = 1; end
                    K_SKP:        e_adv[i] = 0;
                    K_EIE:        begin e_adv[i] = 1; e_prst[i] = (s == 15); end
                    default:      e_adv[i] = 1;
                endcase
            end
            if (dis) e_scr = '0;
            if (counts) begin
                m_pos = (first + 4) % 16;
                m_live = (m_pos != 0);
            end
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ":data_out"}, data_out, e_data);
        chk({tag, ":datak_out"}, 32'(datak_out), 32'(e_datak));
        chk({tag, ":scr_en"}, 32'(scr_en), 32'(e_scr));
        chk({tag, ":advance"}, 32'(advance), 32'(e_adv));
        chk({tag, ":pattern_reset"}, 32'(pattern_reset), 32'(e_prst));
        chk({tag, ":block_err"}, 32'(block_err), 32'(e_err));
    endtask

    // Drives one word, lets the DUT register it, then checks against the model.
    task automatic drive(string tag, bit v, bit [2:0] g, bit dis, logic [31:0] d,
                         logic [3:0] k, bit bs, logic [1:0] sh);
        in_valid = v; gen = g; scr_disable = dis; data_in = d; datak_in = k;
        block_start = bs; sync_header = sh;
        @(posedge pclk);
        model_step(v, g, dis, d, k, bs, sh);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(string tag);
        reset_n = 1'b0;
        @(posedge pclk);
        model_reset();
        #1;
        compare_all(tag);
        reset_n = 1'b1;
    endtask

    task automatic chk_ctrl(string tag, logic [3:0] s, logic [3:0] a, logic [3:0] p, logic e);
        chk({tag, ":scr_en"}, 32'(scr_en), 32'(s));
        chk({tag, ":advance"}, 32'(advance), 32'(a));
        chk({tag, ":pattern_reset"}, 32'(pattern_reset), 32'(p));
        chk({tag, ":block_err"}, 32'(block_err), 32'(e));
    endtask

    task automatic gen3_block(string tag, logic [1:0] sh, logic [7:0] b0, int words);
        for (int w = 0; w < words; w++) begin
            if (w == 0) drive(tag, 1, 3, 0, {$urandom(), 24'h0} | 32'(b0), 4'h0, 1, sh);
            else drive(tag, 1, 3, 0, $urandom(), 4'h0, 0, 2'b00);
        end
    endtask

    initial begin
        logic [7:0] b0s [5];
        logic [31:0] rd;
        logic [3:0] rk;
        b0s[0] = 8'h1E; b0s[1] = 8'h2D; b0s[2] = 8'hAA; b0s[3] = 8'h00; b0s[4] = 8'h55;
        reset_n = 0; gen = 3'd1; scr_disable = 0; in_valid = 0; data_in = '0;
        datak_in = '0; block_start = 0; sync_header = 2'b00;
        model_reset();
        @(posedge pclk);
        do_reset("reset");
        chk_ctrl("reset_const", 4'h0, 4'h0, 4'h0, 1'b0);

        drive("g1_os", 1, 1, 0, {8'h1C, 8'h1C, 8'h1C, 8'hBC}, 4'hF, 0, 2'b00);
        chk_ctrl("g1_os_const", 4'h0, 4'h1, 4'h1, 1'b0);
        drive("g1_data", 1, 1, 0, 32'h44332211, 4'h0, 0, 2'b00);
        chk_ctrl("g1_data_const", 4'hF, 4'hF, 4'h0, 1'b0);
        drive("g1_dis", 1, 1, 1, 32'h44332211, 4'h0, 0, 2'b00);
        chk_ctrl("g1_dis_const", 4'h0, 4'hF, 4'hF, 1'b0);

        drive("ts1_w0", 1, 3, 0, 32'h4A4A4A1E, 4'h0, 1, 2'b10);
        chk_ctrl("ts1_w0_const", 4'hE, 4'hF, 4'h0, 1'b0);
        for (int w = 1; w < 4; w++) begin
            drive("ts1_wn", 1, 3, 0, 32'h4A4A4A4A, 4'h0, 0, 2'b00);
            chk_ctrl("ts1_wn_const", 4'hF, 4'hF, 4'h0, 1'b0);
        end

        for (int w = 0; w < 4; w++) begin
            drive("eieos", 1, 3, 0, 32'h0, 4'h0, w == 0, 2'b10);
            chk_ctrl("eieos_const", 4'h0, 4'hF, (w == 3) ? 4'h8 : 4'h0, 1'b0);
        end

        for (int w = 0; w < 4; w++) begin
            drive("skp", 1, 3, 0, 32'hAAAAAAAA, 4'h0, w == 0, 2'b10);
            chk_ctrl("skp_const", 4'h0, 4'h0, 4'h0, 1'b0);
        end
        for (int w = 0; w < 4; w++) begin
            drive("data_blk", 1, 3, 0, $urandom(), 4'h0, w == 0, 2'b01);
            chk_ctrl("data_blk_const", 4'hF, 4'hF, 4'h0, 1'b0);
        end

        gen3_block("ts2_part", 2'b10, 8'h2D, 2);
        drive("early_start", 1, 3, 0, 32'h12345678, 4'h0, 1, 2'b01);
        chk_ctrl("early_start_const", 4'hF, 4'hF, 4'h0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            drive("realigned", 1, 3, 0, $urandom(), 4'h0, 0, 2'b00);
            chk_ctrl("realigned_const", 4'hF, 4'hF, 4'h0, 1'b0);
        end
        drive("bad_hdr", 1, 3, 0, 32'h0000001E, 4'h0, 1, 2'b11);
        chk_ctrl("bad_hdr_const", 4'h0, 4'hF, 4'h0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            drive("bad_hdr_rest", 1, 3, 0, $urandom(), 4'h0, 0, 2'b00);
            chk_ctrl("bad_hdr_rest_const", 4'h0, 4'hF, 4'h0, 1'b0);
        end

        drive("idle", 0, 3, 0, $urandom(), 4'h0, 0, 2'b00);
        chk_ctrl("idle_const", 4'h0, 4'h0, 4'h0, 1'b0);

        gen3_block("pre_reset", 2'b01, 8'h00, 2);
        in_valid = 1; data_in = 32'hDEADBEEF; block_start = 0;
        do_reset("mid_reset");
        drive("orphan", 1, 3, 0, $urandom(), 4'h0, 0, 2'b00);
        chk_ctrl("orphan_const", 4'h0, 4'hF, 4'h0, 1'b1);

        gen3_block("pre_genchg", 2'b01, 8'h00, 2);
        drive("genchg_g1", 1, 2, 0, 32'h44332211, 4'h0, 0, 2'b00);
        drive("genchg_g3", 1, 3, 0, $urandom(), 4'h0, 0, 2'b00);
        chk_ctrl("genchg_g3_const", 4'h0, 4'hF, 4'h0, 1'b1);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    rd = $urandom();
                    rk = 4'($urandom());
                    for (int i = 0; i < 4; i++) begin
                        case ($urandom_range(0, 3))
                            0: rd[8*i +: 8] = 8'hBC;
                            1: rd[8*i +: 8] = 8'h1C;
                            default: ;
                        endcase
                    end
                    drive("rand_g12", $urandom_range(0, 7) != 0, 3'($urandom_range(1, 2)),
                          1'($urandom_range(0, 1)), rd, rk, 1'($urandom()), 2'($urandom()));
                end
                1: drive("rand_orphan", 1, 3'($urandom_range(3, 5)), 1'($urandom_range(0, 1)),
                         $urandom(), 4'($urandom()), 0, 2'($urandom()));
                default: begin
                    logic [2:0] g3;
                    logic [1:0] sh;
                    bit dis;
                    g3 = 3'($urandom_range(3, 4));
                    dis = ($urandom_range(0, 3) == 0);
                    sh = ($urandom_range(0, 9) == 0) ? 2'($urandom()) : 2'($urandom_range(1, 2));
                    for (int w = 0; w < 4; w++) begin
                        bit bs;
                        rd = $urandom();
                        bs = (w == 0) || ($urandom_range(0, 11) == 0);
                        if (w == 0) rd[7:0] = b0s[$urandom_range(0, 4)];
                        if ($urandom_range(0, 9) == 0)
                            drive("rand_idle", 0, g3, dis, $urandom(), 4'h0, 0, 2'b00);
                        drive("rand_g3", 1, g3, dis, rd, 4'($urandom()), bs, sh);
                    end
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
